bonus_pickup_arbiter: RTL and testbench

- Sits directly downstream of the bonus-car sprite generator and the player-car sprite generator, ahead of the final VGA colour mux.
- Per pixel: merges the two sprite colours by priority and counts overlapping opaque pixels.
- Once per frame: decides whether the player collected the bonus car. If so, it pulses a score award and hides the bonus car for a cooldown period.

---
 rtl/bonus_pickup_arbiter.sv | 102 ++++++++++
 tb/tb_bonus_pickup_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bonus_pickup_arbiter.sv
// bonus_pickup_arbiter: merges player/bonus sprite layers and detects a
// once-per-frame bonus-car pickup, then hides the bonus car for a cooldown.
module bonus_pickup_arbiter #(
    parameter logic [7:0]  MASK_VALUE      = 8'h62,
    parameter int unsigned MIN_OVERLAP     = 4,
    parameter int unsigned COOLDOWN_FRAMES = 60,
    parameter int unsigned BONUS_POINTS    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       game_restart,
    input  logic [7:0] player_color,
    input  logic [7:0] bonus_color,
    output logic [7:0] output_color,
    output logic       bonus_hide,
    output logic       bonus_hit,
    output logic [9:0] score_add,
    output logic [7:0] hit_count
);

    localparam logic [7:0] MIN_OVL = 8'(MIN_OVERLAP);
    localparam logic [9:0] CD_INIT = 10'(COOLDOWN_FRAMES);
    localparam logic [9:0] POINTS  = 10'(BONUS_POINTS);

    typedef enum logic {ARMED, HIDDEN} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] overlap_cnt;
    logic [9:0] cooldown_cnt;
    logic       clear;
    logic       player_opaque;
    logic       bonus_opaque;
    logic       pickup;
    logic       release_hide;

    assign clear         = reset | game_restart;
    assign player_opaque = (player_color != MASK_VALUE);
    assign bonus_opaque  = (bonus_color != MASK_VALUE);

    always_ff @(posedge clk) begin
        if (clear) state <= ARMED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ARMED:   if (frame_start && overlap_cnt >= MIN_OVL) state_next = HIDDEN;
            HIDDEN:  if (frame_start && cooldown_cnt <= 10'd1) state_next = ARMED;
            default: state_next = ARMED;
        endcase
    end

    always_comb begin
        pickup       = 1'b0;
        release_hide = 1'b0;
        case (state)
            ARMED:   pickup = frame_start && (overlap_cnt >= MIN_OVL);
            HIDDEN:  release_hide = frame_start && (cooldown_cnt <= 10'd1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            overlap_cnt  <= '0;
            cooldown_cnt <= '0;
            output_color <= MASK_VALUE;
            bonus_hide   <= 1'b0;
            bonus_hit    <= 1'b0;
            score_add    <= '0;
            hit_count    <= '0;
        end else begin
            bonus_hit <= pickup;
            score_add <= pickup ? POINTS : 10'd0;

            if (player_opaque)                   output_color <= player_color;
            else if (bonus_opaque && !bonus_hide) output_color <= bonus_color;
            else                                 output_color <= MASK_VALUE;

            // frame_start pixel is dropped; count restarts each frame
            if (frame_start)
                overlap_cnt <= '0;
            else if (state == ARMED && player_opaque && bonus_opaque
                     && overlap_cnt != 8'hFF)
                overlap_cnt <= overlap_cnt + 8'd1;

            if (pickup) begin
                cooldown_cnt <= CD_INIT;
                bonus_hide   <= 1'b1;
                if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            end else if (release_hide) begin
                bonus_hide <= 1'b0;
            end else if (state == HIDDEN && frame_start) begin
                cooldown_cnt <= cooldown_cnt - 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_bonus_pickup_arbiter.sv
// tb_bonus_pickup_arbiter: scoreboard bench for the sprite merge and
// bonus pickup/cooldown logic.
module tb_bonus_pickup_arbiter;

    localparam logic [7:0] MASK = 8'h62;
    localparam int         MINO = 4;
    localparam int         CD   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       game_restart = 1'b0;
    logic [7:0] player_color = MASK;
    logic [7:0] bonus_color = MASK;
    logic [7:0] output_color;
    logic       bonus_hide;
    logic       bonus_hit;
    logic [9:0] score_add;
    logic [7:0] hit_count;

    int n_chk = 0;
    int n_pass = 0;

    bit       m_armed = 1'b1;
    int       m_ovl = 0;
    int       m_cd = 0;
    bit       m_hide = 1'b0;
    int       m_hits = 0;
    logic [27:0] sb[$];

    wire [27:0] obs = {output_color, bonus_hide, bonus_hit, score_add, hit_count};

    bonus_pickup_arbiter #(
        .MASK_VALUE(MASK),
        .MIN_OVERLAP(MINO),
        .COOLDOWN_FRAMES(CD),
        .BONUS_POINTS(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .game_restart(game_restart),
        .player_color(player_color),
        .bonus_color(bonus_color),
        .output_color(output_color),
        .bonus_hide(bonus_hide),
        .bonus_hit(bonus_hit),
        .score_add(score_add),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rp();
        return 8'h80 | 8'($urandom_range(0, 127));
    endfunction

    function automatic logic [7:0] rb();
        return 8'($urandom_range(0, 8'h5F));
    endfunction

    // drive one pixel, advance the reference model, queue the expectation
    task automatic step(input bit rs, input bit gr, input bit fs,
                        input logic [7:0] p, input logic [7:0] b);
        logic [7:0] c;
        bit         hit;
        bit         po;
        bit         bo;
        reset = rs;
        game_restart = gr;
        frame_start = fs;
        player_color = p;
        bonus_color = b;
        po = (p != MASK);
        bo = (b != MASK);
        c = po ? p : ((bo && !m_hide) ? b : MASK);
        hit = 1'b0;
        if (rs || gr) begin
            m_armed = 1'b1; m_ovl = 0; m_cd = 0; m_hide = 1'b0; m_hits = 0;
            c = MASK;
        end else if (fs) begin
            if (m_armed && m_ovl >= MINO) begin
                hit = 1'b1;
                if (m_hits < 255) m_hits++;
                m_cd = CD; m_hide = 1'b1; m_armed = 1'b0;
            end else if (!m_armed) begin
                if (m_cd <= 1) begin m_armed = 1'b1; m_hide = 1'b0; end
                else m_cd--;
            end
            m_ovl = 0;
        end else if (m_armed && po && bo && m_ovl < 255) begin
            m_ovl++;
        end
        sb.push_back({c, m_hide, hit, hit ? 10'd100 : 10'd0, 8'(m_hits)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [27:0] e;
        step(1, 0, 0, MASK, MASK);
        e = sb.pop_front(); n_chk++;
        if (obs !== e) $display("FAIL reset got=%h exp=%h", obs, e);
        else n_pass++;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 6; i++) begin
                step(0, 0, i == 5, MASK, MASK);
                e = sb.pop_front(); n_chk++;
                if (obs !== e) $display("FAIL idle got=%h exp=%h", obs, e);
                else n_pass++;
            end
        end
        n_chk++;
        if (output_color !== 8'h62 || bonus_hit !== 1'b0 || hit_count !== 8'd0)
            $display("FAIL idle_const got=%h/%b/%0d exp=62/0/0",
                     output_color, bonus_hit, hit_count);
        else n_pass++;
    endtask

    task automatic test_merge();
        logic [27:0] e;
        step(0, 0, 0, 8'hE4, 8'h1F);
        e = sb.pop_front(); n_chk++;
        if (obs !== e || output_color !== 8'hE4)
            $display("FAIL merge_player got=%h exp=%h", obs, e);
        else n_pass++;
        step(0, 0, 0, MASK, 8'h1F);
        e = sb.pop_front(); n_chk++;
        if (obs !== e || output_color !== 8'h1F)
            $display("FAIL merge_bonus got=%h exp=%h", obs, e);
        else n_pass++;
        step(0, 0, 1, MASK, MASK);
        e = sb.pop_front(); n_chk++;
        if (obs !== e) $display("FAIL merge_fs got=%h exp=%h", obs, e);
        else n_pass++;
    endtask

    task automatic test_threshold();
        logic [27:0] e;
        for (int i = 0; i < 4; i++) begin
            // the 4th overlapping pixel lands on the frame_start cycle
            step(0, 0, i == 3, rp(), rb());
            e = sb.pop_front(); n_chk++;
            if (obs !== e) $display("FAIL threshold got=%h exp=%h", obs, e);
            else n_pass++;
        end
        n_chk++;
        if (bonus_hit !== 1'b0 || bonus_hide !== 1'b0)
            $display("FAIL threshold_nohit got=%b/%b exp=0/0", bonus_hit, bonus_hide);
        else n_pass++;
        step(0, 0, 1, MASK, MASK);
        e = sb.pop_front(); n_chk++;
        if (obs !== e || bonus_hit !== 1'b0)
            $display("FAIL threshold_clear got=%h exp=%h", obs, e);
        else n_pass++;
    endtask

    task automatic test_pickup();
        logic [27:0] e;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, i == 4, rp(), rb());
            e = sb.pop_front(); n_chk++;
            if (obs !== e) $display("FAIL pickup got=%h exp=%h", obs, e);
            else n_pass++;
        end
        n_chk++;
        if (bonus_hit !== 1'b1 || score_add !== 10'd100 || hit_count !== 8'd1
            || bonus_hide !== 1'b1)
            $display("FAIL pickup_pulse got=%b/%0d/%0d/%b exp=1/100/1/1",
                     bonus_hit, score_add, hit_count, bonus_hide);
        else n_pass++;
        step(0, 0, 0, MASK, MASK);
        e = sb.pop_front(); n_chk++;
        if (obs !== e || bonus_hit !== 1'b0 || score_add !== 10'd0)
            $display("FAIL pickup_once got=%b/%0d exp=0/0", bonus_hit, score_add);
        else n_pass++;
    endtask

    task automatic test_cooldown();
        logic [27:0] e;
        for (int f = 1; f <= CD; f++) begin
            step(0, 0, 0, MASK, 8'h1F);
            e = sb.pop_front(); n_chk++;
            if (obs !== e || output_color !== MASK)
                $display("FAIL cd_masked got=%h exp=%h", obs, e);
            else n_pass++;
            for (int i = 0; i < 5; i++) begin
                step(0, 0, i == 4, rp(), rb());
                e = sb.pop_front(); n_chk++;
                if (obs !== e) $display("FAIL cd_frame got=%h exp=%h", obs, e);
                else n_pass++;
            end
            n_chk++;
            if (bonus_hit !== 1'b0 || bonus_hide !== (f < CD))
                $display("FAIL cd_hide f=%0d got=%b/%b exp=0/%b",
                         f, bonus_hit, bonus_hide, f < CD);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, i == 4, rp(), rb());
            e = sb.pop_front(); n_chk++;
            if (obs !== e) $display("FAIL rearm got=%h exp=%h", obs, e);
            else n_pass++;
        end
        n_chk++;
        if (bonus_hit !== 1'b1 || hit_count !== 8'd2)
            $display("FAIL rearm_pulse got=%b/%0d exp=1/2", bonus_hit, hit_count);
        else n_pass++;
    endtask

    task automatic test_restart();
        logic [27:0] e;
        step(0, 0, 1, MASK, MASK);
        e = sb.pop_front(); n_chk++;
        if (obs !== e) $display("FAIL restart_pre got=%h exp=%h", obs, e);
        else n_pass++;
        step(0, 1, 1, rp(), rb());
        e = sb.pop_front(); n_chk++;
        if (obs !== e || bonus_hide !== 1'b0 || hit_count !== 8'd0
            || bonus_hit !== 1'b0)
            $display("FAIL restart got=%h exp=%h", obs, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [27:0] e;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, i >= 4, (i < 4) ? rp() : MASK, (i < 4) ? rb() : MASK);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) $display("FAIL b2b got=%h exp=%h", obs, e);
            else n_pass++;
        end
        n_chk++;
        if (bonus_hit !== 1'b0 || bonus_hide !== 1'b1 || hit_count !== 8'd1)
            $display("FAIL b2b_second got=%b/%b/%0d exp=0/1/1",
                     bonus_hit, bonus_hide, hit_count);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, MASK, MASK);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) $display("FAIL b2b_cd got=%h exp=%h", obs, e);
            else n_pass++;
        end
        n_chk++;
        if (bonus_hide !== 1'b0)
            $display("FAIL b2b_release got=%b exp=0", bonus_hide);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [27:0] e;
        step(0, 1, 0, MASK, MASK);
        e = sb.pop_front(); n_chk++;
        if (obs !== e) $display("FAIL sat_restart got=%h exp=%h", obs, e);
        else n_pass++;
        for (int k = 0; k < 257; k++) begin
            for (int i = 0; i < 5 + CD; i++) begin
                step(0, 0, i >= 4, (i < 4) ? rp() : MASK, (i < 4) ? rb() : MASK);
                e = sb.pop_front(); n_chk++;
                if (obs !== e) $display("FAIL sat k=%0d got=%h exp=%h", k, obs, e);
                else n_pass++;
            end
        end
        n_chk++;
        if (hit_count !== 8'd255)
            $display("FAIL sat_hold got=%0d exp=255", hit_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_merge();
        test_threshold();
        test_pickup();
        test_cooldown();
        test_restart();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
